// File: rtl/freqmeter_pkg.sv
// ============================================================================
// Module   : freqmeter_pkg
// Brief    : Register map, bit positions and FSM encoding for wb_freqmeter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package freqmeter_pkg;

    // Register word indices (byte address bits [3:2])
    localparam logic [1:0] C_REG_CTRL   = 2'd0;
    localparam logic [1:0] C_REG_GATE   = 2'd1;
    localparam logic [1:0] C_REG_RESULT = 2'd2;
    localparam logic [1:0] C_REG_STATUS = 2'd3;

    localparam int C_CTRL_EN     = 0;
    localparam int C_CTRL_IRQ_EN = 1;
    localparam int C_CTRL_SINGLE = 2;

    localparam int C_STAT_VALID   = 0;
    localparam int C_STAT_SAT     = 1;
    localparam int C_STAT_OVERRUN = 2;

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_MEAS = 1'b1;

    localparam logic [31:0] C_GATE_MIN = 32'd2;

    function automatic logic [31:0] clamp_gate(input logic [31:0] value);
        return (value < C_GATE_MIN) ? C_GATE_MIN : value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_freqmeter_sync_edge.sv
// ============================================================================
// Module   : sync_edge
// Brief    : 2-FF synchronizer plus one-cycle rising-edge pulse generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_edge
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= i_async;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign o_edge = sync2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/wb_freqmeter.sv
// ============================================================================
// Module   : wb_freqmeter
// Brief    : Wishbone slave counting osc_i rising edges over a gate window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_freqmeter
    import freqmeter_pkg::*;
#(
    parameter int clk_freq  = 50_000_000,
    parameter int cnt_width = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic        osc_i,
    output logic        intr
);

    localparam logic [31:0]          C_GATE_RST = 32'(clk_freq / 1000);
    localparam logic [cnt_width-1:0] C_CNT_ONE  = {{(cnt_width-1){1'b0}}, 1'b1};

    logic                 ack_q, ack_d;
    logic [31:0]          dat_q, dat_d;
    logic                 en_q, en_d, irq_en_q, irq_en_d, single_q, single_d;
    logic [31:0]          gate_q, gate_d, gate_snap_q, gate_snap_d;
    logic [31:0]          gate_cnt_q, gate_cnt_d;
    logic [cnt_width-1:0] edge_cnt_q, edge_cnt_d, result_q, result_d;
    logic                 sat_flag_q, sat_flag_d;
    logic                 valid_q, valid_d, sat_q, sat_d, overrun_q, overrun_d;
    logic [0:0]           state_q, state_d;

    logic                 w_edge, w_acc, w_wr, w_last, w_sat_next;
    logic [1:0]           w_idx;
    logic [31:0]          w_rdata;
    logic [cnt_width-1:0] w_cnt_next;
    logic                 w_unused;

    // Full-word access only: byte lanes and address bits outside [3:2] are don't-care
    assign w_unused = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};

    sync_edge u_sync_edge (
        .clk     (clk),
        .rst     (reset),
        .i_async (osc_i),
        .o_edge  (w_edge)
    );

    assign w_acc = wb_stb_i & wb_cyc_i & ~ack_q;
    assign w_wr  = w_acc & wb_we_i;
    assign w_idx = wb_adr_i[3:2];

    assign w_last     = (gate_cnt_q == gate_snap_q - 32'd1);
    assign w_cnt_next = (w_edge && !(&edge_cnt_q)) ? edge_cnt_q + C_CNT_ONE : edge_cnt_q;
    assign w_sat_next = sat_flag_q | (w_edge & (&edge_cnt_q));

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            C_REG_CTRL: begin
                w_rdata[C_CTRL_EN]     = en_q;
                w_rdata[C_CTRL_IRQ_EN] = irq_en_q;
                w_rdata[C_CTRL_SINGLE] = single_q;
            end
            C_REG_GATE:   w_rdata = gate_q;
            C_REG_RESULT: w_rdata = 32'(result_q);
            default: begin
                w_rdata[C_STAT_VALID]   = valid_q;
                w_rdata[C_STAT_SAT]     = sat_q;
                w_rdata[C_STAT_OVERRUN] = overrun_q;
            end
        endcase
    end

    always_comb begin
        ack_d       = w_acc;
        dat_d       = w_acc ? w_rdata : dat_q;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        single_d    = single_q;
        gate_d      = gate_q;
        gate_snap_d = gate_snap_q;
        gate_cnt_d  = gate_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        sat_flag_d  = sat_flag_q;
        result_d    = result_q;
        valid_d     = valid_q;
        sat_d       = sat_q;
        overrun_d   = overrun_q;
        state_d     = state_q;

        if (w_wr) begin
            case (w_idx)
                C_REG_CTRL: begin
                    en_d     = wb_dat_i[C_CTRL_EN];
                    irq_en_d = wb_dat_i[C_CTRL_IRQ_EN];
                    single_d = wb_dat_i[C_CTRL_SINGLE];
                end
                C_REG_GATE: gate_d = clamp_gate(wb_dat_i);
                C_REG_STATUS: begin
                    valid_d   = valid_q   & ~wb_dat_i[C_STAT_VALID];
                    sat_d     = sat_q     & ~wb_dat_i[C_STAT_SAT];
                    overrun_d = overrun_q & ~wb_dat_i[C_STAT_OVERRUN];
                end
                default: ;
            endcase
        end

        // Hardware updates come after the bus write so a latch beats a W1C
        if (state_q == C_ST_IDLE) begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            sat_flag_d = 1'b0;
            if (en_d) begin
                state_d     = C_ST_MEAS;
                gate_snap_d = gate_d;
            end
        end else if (!en_q) begin
            state_d    = C_ST_IDLE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            sat_flag_d = 1'b0;
        end else if (w_last) begin
            result_d    = w_cnt_next;
            sat_d       = w_sat_next;
            overrun_d   = overrun_d | valid_q;
            valid_d     = 1'b1;
            gate_cnt_d  = '0;
            edge_cnt_d  = '0;
            sat_flag_d  = 1'b0;
            gate_snap_d = gate_d;
            if (single_q) begin
                en_d    = 1'b0;
                state_d = C_ST_IDLE;
            end
        end else begin
            gate_cnt_d = gate_cnt_q + 32'd1;
            edge_cnt_d = w_cnt_next;
            sat_flag_d = w_sat_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            single_q    <= 1'b0;
            gate_q      <= C_GATE_RST;
            gate_snap_q <= C_GATE_RST;
            gate_cnt_q  <= '0;
            edge_cnt_q  <= '0;
            sat_flag_q  <= 1'b0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            sat_q       <= 1'b0;
            overrun_q   <= 1'b0;
            state_q     <= C_ST_IDLE;
        end else begin
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            single_q    <= single_d;
            gate_q      <= gate_d;
            gate_snap_q <= gate_snap_d;
            gate_cnt_q  <= gate_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            sat_flag_q  <= sat_flag_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            sat_q       <= sat_d;
            overrun_q   <= overrun_d;
            state_q     <= state_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign intr     = valid_q & irq_en_q;

endmodule

`default_nettype wire
